// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: memory access codes,
// next-PC select values, FSM states and the load classifier.
package pipe_ctrl_pkg;

    typedef enum logic [3:0] {
        MEM_NO_RW = 4'd0,
        MEM_LB    = 4'd1,
        MEM_LH    = 4'd2,
        MEM_LW    = 4'd3,
        MEM_LBU   = 4'd4,
        MEM_LHU   = 4'd5,
        MEM_SB    = 4'd6,
        MEM_SH    = 4'd7,
        MEM_SW    = 4'd8
    } mem_rw_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] code);
        logic res;
        res = 1'b0;
        case (code)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: res = 1'b1;
            default:                                  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stalls, load-use
// interlock, branch/jump redirect, performance counters and wait timeout.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_INIT     | first cycle after reset; pipeline flushed, fetch held
// ST_RUN      | normal issue; hazards resolved combinationally
// ST_MEM_WAIT | M-stage access outstanding; E/M held until ready
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       decode_i_rs1,
    input  logic [4:0]       decode_i_rs2,
    input  logic             decode_i_need_jump,
    input  logic             decode_i_is_jalr,
    input  logic [3:0]       regE_i_mem_rw,
    input  logic [4:0]       regE_i_wb_rd,
    input  logic [3:0]       regM_i_mem_rw,
    input  logic             dmem_i_ready,
    output logic             ctrl_o_FD_stall,
    output logic             ctrl_o_D_bubble,
    output logic             ctrl_o_E_bubble,
    output logic             ctrl_o_EM_stall,
    output logic             ctrl_o_W_bubble,
    output logic [1:0]       ctrl_o_pc_sel,
    output logic [CNT_W-1:0] ctrl_o_stall_cnt,
    output logic [CNT_W-1:0] ctrl_o_flush_cnt,
    output logic             ctrl_o_mem_timeout
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);

    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_init;
    logic              mem_wait;
    logic              load_use;
    logic              redirect;

    // Hazard classification in strict priority order; each term masks the lower ones.
    always_comb begin
        in_init  = !rst || (state == ST_INIT);
        mem_wait = !in_init && (regM_i_mem_rw != MEM_NO_RW) && !dmem_i_ready;
        load_use = !in_init && !mem_wait && is_load(regE_i_mem_rw) &&
                   (regE_i_wb_rd != 5'd0) &&
                   ((regE_i_wb_rd == decode_i_rs1) || (regE_i_wb_rd == decode_i_rs2));
        redirect = !in_init && !mem_wait && !load_use && decode_i_need_jump;
    end

    always_comb begin
        ctrl_o_FD_stall = 1'b0;
        ctrl_o_D_bubble = 1'b0;
        ctrl_o_E_bubble = 1'b0;
        ctrl_o_EM_stall = 1'b0;
        ctrl_o_W_bubble = 1'b0;
        ctrl_o_pc_sel   = PC_PLUS4;
        if (in_init) begin
            ctrl_o_FD_stall = 1'b1;
            ctrl_o_D_bubble = 1'b1;
            ctrl_o_E_bubble = 1'b1;
            ctrl_o_W_bubble = 1'b1;
        end else if (mem_wait) begin
            ctrl_o_FD_stall = 1'b1;
            ctrl_o_EM_stall = 1'b1;
            ctrl_o_W_bubble = 1'b1;
        end else if (load_use) begin
            ctrl_o_FD_stall = 1'b1;
            ctrl_o_E_bubble = 1'b1;
        end else if (redirect) begin
            ctrl_o_D_bubble = 1'b1;
            ctrl_o_pc_sel   = decode_i_is_jalr ? PC_JALR : PC_BRANCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= ST_INIT;
            wait_cnt           <= '0;
            ctrl_o_mem_timeout <= 1'b0;
            ctrl_o_stall_cnt   <= '0;
            ctrl_o_flush_cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: state <= ST_RUN;
                ST_RUN: begin
                    if (mem_wait)
                        state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (dmem_i_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != WAIT_LIM)
                            wait_cnt <= wait_cnt + 1'b1;
                        // Flag is raised by the edge that completes the TIMEOUT-th wait cycle.
                        if (wait_cnt >= WAIT_LIM - 1'b1)
                            ctrl_o_mem_timeout <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase

            if (ctrl_o_FD_stall && (ctrl_o_stall_cnt != '1))
                ctrl_o_stall_cnt <= ctrl_o_stall_cnt + 1'b1;
            if (redirect && (ctrl_o_flush_cnt != '1))
                ctrl_o_flush_cnt <= ctrl_o_flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard priority, redirects, memory waits,
// timeout, counter saturation and reset behaviour.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    // {FD_stall, D_bubble, E_bubble, EM_stall, W_bubble, pc_sel[1:0]}
    localparam logic [6:0] V_INIT = 7'b1110100;
    localparam logic [6:0] V_NORM = 7'b0000000;
    localparam logic [6:0] V_LU   = 7'b1010000;
    localparam logic [6:0] V_MW   = 7'b1001100;
    localparam logic [6:0] V_BR   = 7'b0100001;
    localparam logic [6:0] V_JR   = 7'b0100010;

    logic             clk;
    logic             rst;
    logic [4:0]       decode_i_rs1;
    logic [4:0]       decode_i_rs2;
    logic             decode_i_need_jump;
    logic             decode_i_is_jalr;
    logic [3:0]       regE_i_mem_rw;
    logic [4:0]       regE_i_wb_rd;
    logic [3:0]       regM_i_mem_rw;
    logic             dmem_i_ready;
    logic             ctrl_o_FD_stall;
    logic             ctrl_o_D_bubble;
    logic             ctrl_o_E_bubble;
    logic             ctrl_o_EM_stall;
    logic             ctrl_o_W_bubble;
    logic [1:0]       ctrl_o_pc_sel;
    logic [CNT_W-1:0] ctrl_o_stall_cnt;
    logic [CNT_W-1:0] ctrl_o_flush_cnt;
    logic             ctrl_o_mem_timeout;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .decode_i_rs1       (decode_i_rs1),
        .decode_i_rs2       (decode_i_rs2),
        .decode_i_need_jump (decode_i_need_jump),
        .decode_i_is_jalr   (decode_i_is_jalr),
        .regE_i_mem_rw      (regE_i_mem_rw),
        .regE_i_wb_rd       (regE_i_wb_rd),
        .regM_i_mem_rw      (regM_i_mem_rw),
        .dmem_i_ready       (dmem_i_ready),
        .ctrl_o_FD_stall    (ctrl_o_FD_stall),
        .ctrl_o_D_bubble    (ctrl_o_D_bubble),
        .ctrl_o_E_bubble    (ctrl_o_E_bubble),
        .ctrl_o_EM_stall    (ctrl_o_EM_stall),
        .ctrl_o_W_bubble    (ctrl_o_W_bubble),
        .ctrl_o_pc_sel      (ctrl_o_pc_sel),
        .ctrl_o_stall_cnt   (ctrl_o_stall_cnt),
        .ctrl_o_flush_cnt   (ctrl_o_flush_cnt),
        .ctrl_o_mem_timeout (ctrl_o_mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic nj, input logic jalr,
                         input logic [3:0] erw, input logic [4:0] erd,
                         input logic [3:0] mrw, input logic rdy);
        decode_i_rs1       = rs1;
        decode_i_rs2       = rs2;
        decode_i_need_jump = nj;
        decode_i_is_jalr   = jalr;
        regE_i_mem_rw      = erw;
        regE_i_wb_rd       = erd;
        regM_i_mem_rw      = mrw;
        dmem_i_ready       = rdy;
    endtask

    // Advance to the next falling edge, apply inputs, let combinational outputs settle.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic nj, input logic jalr,
                        input logic [3:0] erw, input logic [4:0] erd,
                        input logic [3:0] mrw, input logic rdy);
        @(negedge clk);
        drive(rs1, rs2, nj, jalr, erw, erd, mrw, rdy);
        #1;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_NO_RW, 1'b1);
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {ctrl_o_FD_stall, ctrl_o_D_bubble, ctrl_o_E_bubble,
               ctrl_o_EM_stall, ctrl_o_W_bubble, ctrl_o_pc_sel};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_NO_RW, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_ctrl("reset_outputs", V_INIT);
        chk("reset_stall_cnt", int'(ctrl_o_stall_cnt), 0);
        chk("reset_flush_cnt", int'(ctrl_o_flush_cnt), 0);
        chk("reset_timeout", int'(ctrl_o_mem_timeout), 0);

        // Release reset: one INIT cycle still drives the flush pattern.
        @(negedge clk); rst = 1'b1; #1;
        chk_ctrl("init_cycle", V_INIT);

        idle();
        chk_ctrl("normal_flow", V_NORM);
        chk("stall_after_init", int'(ctrl_o_stall_cnt), 1);

        // lw x5 in E, add x6,x5,x1 in D
        step(5'd5, 5'd1, 1'b0, 1'b0, MEM_LW, 5'd5, MEM_NO_RW, 1'b1);
        chk_ctrl("load_use_rs1", V_LU);
        idle();
        chk_ctrl("load_use_one_cycle", V_NORM);
        chk("stall_after_lu", int'(ctrl_o_stall_cnt), 2);

        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_LW, 5'd0, MEM_NO_RW, 1'b1);
        chk_ctrl("load_x0_no_stall", V_NORM);
        step(5'd5, 5'd0, 1'b0, 1'b0, MEM_SW, 5'd5, MEM_NO_RW, 1'b1);
        chk_ctrl("store_no_hazard", V_NORM);
        step(5'd2, 5'd7, 1'b0, 1'b0, MEM_LBU, 5'd7, MEM_NO_RW, 1'b1);
        chk_ctrl("load_use_rs2", V_LU);
        step(5'd3, 5'd0, 1'b1, 1'b0, MEM_LH, 5'd3, MEM_NO_RW, 1'b1);
        chk_ctrl("load_use_over_jump", V_LU);

        step(5'd0, 5'd0, 1'b1, 1'b0, MEM_NO_RW, 5'd0, MEM_NO_RW, 1'b1);
        chk_ctrl("branch_taken", V_BR);
        step(5'd0, 5'd0, 1'b1, 1'b1, MEM_NO_RW, 5'd0, MEM_NO_RW, 1'b1);
        chk_ctrl("jalr_taken", V_JR);
        idle();
        chk("flush_after_redirects", int'(ctrl_o_flush_cnt), 2);
        chk("stall_after_redirects", int'(ctrl_o_stall_cnt), 4);

        // Access completing in its first cycle: no stall at all.
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_LW, 1'b1);
        chk_ctrl("mem_ready_first", V_NORM);
        idle();
        chk("stall_after_ready_first", int'(ctrl_o_stall_cnt), 4);

        // sw in M, ready low for three cycles, taken branch in the first.
        step(5'd0, 5'd0, 1'b1, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b0);
        chk_ctrl("mem_wait_over_jump", V_MW);
        step(5'd5, 5'd0, 1'b0, 1'b0, MEM_LW, 5'd5, MEM_SW, 1'b0);
        chk_ctrl("mem_wait_over_lu", V_MW);
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b0);
        chk_ctrl("mem_wait_3", V_MW);
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b1);
        chk_ctrl("mem_wait_release", V_NORM);
        idle();
        chk("stall_after_wait", int'(ctrl_o_stall_cnt), 7);
        chk("flush_after_wait", int'(ctrl_o_flush_cnt), 2);
        chk("no_timeout_short_wait", int'(ctrl_o_mem_timeout), 0);

        // Timeout: ready low for six cycles with TIMEOUT=4.
        for (int i = 1; i <= 6; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_LW, 1'b0);
            chk_ctrl("timeout_wait_out", V_MW);
            if (i == 5) chk("timeout_not_yet", int'(ctrl_o_mem_timeout), 0);
            if (i == 6) chk("timeout_raised", int'(ctrl_o_mem_timeout), 1);
        end
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_LW, 1'b1);
        chk_ctrl("timeout_release", V_NORM);
        idle();
        chk("timeout_sticky", int'(ctrl_o_mem_timeout), 1);
        chk("stall_after_timeout", int'(ctrl_o_stall_cnt), 13);

        // Stall counter saturation (13 + 4 clips at 15).
        repeat (4) step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SB, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SB, 1'b1);
        idle();
        chk("stall_saturated", int'(ctrl_o_stall_cnt), 15);

        // Flush counter saturation (2 + 14 clips at 15).
        for (int i = 0; i < 14; i++) begin
            step(5'd0, 5'd0, 1'b1, 1'b0, MEM_NO_RW, 5'd0, MEM_NO_RW, 1'b1);
            chk_ctrl("redirect_loop", V_BR);
        end
        idle();
        chk("flush_saturated", int'(ctrl_o_flush_cnt), 15);

        // Reset in the middle of a memory wait.
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b0);
        chk_ctrl("pre_reset_wait", V_MW);
        @(negedge clk); rst = 1'b0; #1;
        chk_ctrl("reset_mid_wait_out", V_INIT);
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b0);
        chk_ctrl("reset_held_out", V_INIT);
        chk("reset_clears_stall", int'(ctrl_o_stall_cnt), 0);
        chk("reset_clears_flush", int'(ctrl_o_flush_cnt), 0);
        chk("reset_clears_timeout", int'(ctrl_o_mem_timeout), 0);
        @(negedge clk); rst = 1'b1; #1;
        chk_ctrl("post_reset_init", V_INIT);
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b0);
        chk_ctrl("post_reset_wait", V_MW);
        chk("post_reset_stall", int'(ctrl_o_stall_cnt), 1);
        step(5'd0, 5'd0, 1'b0, 1'b0, MEM_NO_RW, 5'd0, MEM_SW, 1'b1);
        chk_ctrl("post_reset_release", V_NORM);
        idle();
        chk("post_reset_stall_final", int'(ctrl_o_stall_cnt), 2);
        chk("post_reset_timeout", int'(ctrl_o_mem_timeout), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
